// File: rtl/sprite_palette_arbiter.sv
// sprite_palette_arbiter
// Round-robin arbiter sharing one combinational palette ROM between NREQ
// sprite drawers. One lookup accepted per cycle; the index is registered
// toward the ROM (stage 1) and the ROM colour is registered back to the
// granted drawer as a one-hot response (stage 2).
module sprite_palette_arbiter #(
  parameter int NREQ = 4
) (
  input  logic              Clk,
  input  logic              Reset_n,
  input  logic              frame_start,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [8*NREQ-1:0] req_index,
  output logic [NREQ-1:0]   req_ready,
  output logic [7:0]        pal_index,
  input  logic [3:0]        pal_red,
  input  logic [3:0]        pal_green,
  input  logic [3:0]        pal_blue,
  output logic [NREQ-1:0]   rsp_valid,
  output logic [3:0]        rsp_red,
  output logic [3:0]        rsp_green,
  output logic [3:0]        rsp_blue,
  output logic              rsp_transparent,
  output logic              busy
);

  localparam int PW = $clog2(NREQ);
  typedef logic [PW-1:0] ptr_t;
  typedef logic [PW:0]   sum_t;

  // Round-robin pointer and stage-1 state
  ptr_t            r_rr_ptr;
  logic [7:0]      r_pal_index;
  logic            r_s1_valid;
  ptr_t            r_s1_owner;
  logic            r_s1_transparent;

  // Stage-2 response registers
  logic [NREQ-1:0] r_rsp_valid;
  logic [3:0]      r_rsp_red;
  logic [3:0]      r_rsp_green;
  logic [3:0]      r_rsp_blue;
  logic            r_rsp_transparent;

  // Grant decode
  logic            w_gnt_any;
  ptr_t            w_gnt_idx;
  logic [NREQ-1:0] w_ready;
  sum_t            w_sum;
  ptr_t            w_cand;
  logic [7:0]      w_gnt_data;
  logic [NREQ-1:0] w_owner_onehot;

  // Search from r_rr_ptr upward (mod NREQ) for the first pending requester.
  always_comb begin
    // NOTE: every signal written here gets a default first so no latch is inferred.
    w_gnt_any = 1'b0;
    w_gnt_idx = '0;
    w_ready   = '0;
    w_sum     = '0;
    w_cand    = '0;
    for (int k = 0; k < NREQ; k++) begin
      w_sum = {1'b0, r_rr_ptr} + sum_t'(k);
      // Explicit wrap so non-power-of-two NREQ works.
      if (w_sum >= sum_t'(NREQ)) w_sum = w_sum - sum_t'(NREQ);
      w_cand = w_sum[PW-1:0];
      if (!w_gnt_any && req_valid[w_cand]) begin
        w_gnt_any = 1'b1;
        w_gnt_idx = w_cand;
      end
    end
    if (w_gnt_any) w_ready[w_gnt_idx] = 1'b1;
  end

  // Select the granted requester's palette index.
  always_comb begin
    w_gnt_data = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (w_gnt_idx == ptr_t'(i)) w_gnt_data = req_index[8*i +: 8];
    end
  end

  // One-hot form of the stage-1 owner for the response.
  always_comb begin
    w_owner_onehot             = '0;
    w_owner_onehot[r_s1_owner] = 1'b1;
  end

  // Pointer update: frame_start restarts priority at 0 and overrides the grant advance.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      r_rr_ptr <= '0;
    end else if (frame_start) begin
      r_rr_ptr <= '0;
    end else if (w_gnt_any) begin
      r_rr_ptr <= (w_gnt_idx == ptr_t'(NREQ-1)) ? '0 : w_gnt_idx + ptr_t'(1);
    end
  end

  // Stage 1: capture the accepted index toward the ROM; index and owner hold when idle.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_pal_index      <= '0;
      r_s1_valid       <= 1'b0;
      r_s1_owner       <= '0;
      r_s1_transparent <= 1'b0;
    end else begin
      r_s1_valid <= w_gnt_any;
      if (w_gnt_any) begin
        r_pal_index      <= w_gnt_data;
        r_s1_owner       <= w_gnt_idx;
        r_s1_transparent <= (w_gnt_data == 8'd0);
      end
    end
  end

  // Stage 2: register the ROM colour; colour and transparency hold between responses.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_rsp_valid       <= '0;
      r_rsp_red         <= '0;
      r_rsp_green       <= '0;
      r_rsp_blue        <= '0;
      r_rsp_transparent <= 1'b0;
    end else begin
      r_rsp_valid <= r_s1_valid ? w_owner_onehot : '0;
      if (r_s1_valid) begin
        r_rsp_red         <= pal_red;
        r_rsp_green       <= pal_green;
        r_rsp_blue        <= pal_blue;
        r_rsp_transparent <= r_s1_transparent;
      end
    end
  end

  assign req_ready       = w_ready;
  assign pal_index       = r_pal_index;
  assign rsp_valid       = r_rsp_valid;
  assign rsp_red         = r_rsp_red;
  assign rsp_green       = r_rsp_green;
  assign rsp_blue        = r_rsp_blue;
  assign rsp_transparent = r_rsp_transparent;
  assign busy            = r_s1_valid | (|r_rsp_valid);

endmodule

// File: tb/tb_sprite_palette_arbiter.sv
// Scoreboard bench for sprite_palette_arbiter: the stimulus process pushes the
// expected response for every grant, a negedge monitor pops and compares each
// response the DUT presents. The palette ROM is a fixed formula in the bench;
// expected colours in the tables below are worked out by hand from it.
module tb_sprite_palette_arbiter;

  localparam int NREQ = 4;

  logic              Clk = 1'b0;
  logic              Reset_n;
  logic              frame_start;
  logic [NREQ-1:0]   req_valid;
  logic [8*NREQ-1:0] req_index;
  logic [NREQ-1:0]   req_ready;
  logic [7:0]        pal_index;
  logic [3:0]        pal_red, pal_green, pal_blue;
  logic [NREQ-1:0]   rsp_valid;
  logic [3:0]        rsp_red, rsp_green, rsp_blue;
  logic              rsp_transparent;
  logic              busy;

  sprite_palette_arbiter #(.NREQ(NREQ)) dut (
    .Clk(Clk), .Reset_n(Reset_n), .frame_start(frame_start),
    .req_valid(req_valid), .req_index(req_index), .req_ready(req_ready),
    .pal_index(pal_index), .pal_red(pal_red), .pal_green(pal_green), .pal_blue(pal_blue),
    .rsp_valid(rsp_valid), .rsp_red(rsp_red), .rsp_green(rsp_green), .rsp_blue(rsp_blue),
    .rsp_transparent(rsp_transparent), .busy(busy)
  );

  always #5 Clk = ~Clk;

  // Palette ROM: red = hi^9, green = lo+A, blue = hi+lo+4 (4-bit wrap).
  assign pal_red   = pal_index[7:4] ^ 4'h9;
  assign pal_green = pal_index[3:0] + 4'hA;
  assign pal_blue  = pal_index[7:4] + pal_index[3:0] + 4'h4;

  typedef struct {
    logic [NREQ-1:0] valid;
    logic [11:0]     rgb;
    logic            t;
    int              cyc;
  } exp_t;

  exp_t        sb[$];
  exp_t        m_e;
  int          n_tests = 0;
  int          n_fail  = 0;
  int          cyc     = 0;
  logic [11:0] tab_rgb [NREQ];
  logic        tab_t   [NREQ];

  always @(posedge Clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Drive one cycle of requests, check the grant, queue the expected response.
  task automatic step(input logic [NREQ-1:0] v, input logic fs,
                      input logic [NREQ-1:0] exp_g, input bit push);
    exp_t e;
    req_valid   = v;
    frame_start = fs;
    #1;
    check("req_ready", 32'(req_ready), 32'(exp_g));
    if (push && exp_g != '0) begin
      for (int i = 0; i < NREQ; i++) begin
        if (exp_g[i]) begin
          e.valid = exp_g;
          e.rgb   = tab_rgb[i];
          e.t     = tab_t[i];
          e.cyc   = cyc + 2;
          sb.push_back(e);
        end
      end
    end
    @(posedge Clk);
    #1;
    frame_start = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step('0, 1'b0, '0, 1'b0);
  endtask

  // Monitor: every response the DUT presents must match the oldest queued expectation.
  always @(negedge Clk) begin
    if (Reset_n === 1'b1 && rsp_valid !== '0) begin
      if (sb.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_rsp: rsp_valid=%b with nothing expected (t=%0t)", rsp_valid, $time);
      end else begin
        m_e = sb.pop_front();
        check("rsp_valid", 32'(rsp_valid), 32'(m_e.valid));
        check("rsp_rgb", 32'({rsp_red, rsp_green, rsp_blue}), 32'(m_e.rgb));
        check("rsp_transparent", 32'(rsp_transparent), 32'(m_e.t));
        check("rsp_latency", cyc, m_e.cyc);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    // Requester indices and hand-computed ROM colours:
    // 0x10 -> 8/A/5, 0x23 -> B/D/9, 0x00 -> 9/A/4 (transparent), 0x5C -> C/6/5
    req_index = '0;
    req_index[8*0 +: 8] = 8'h10; tab_rgb[0] = 12'h8A5; tab_t[0] = 1'b0;
    req_index[8*1 +: 8] = 8'h23; tab_rgb[1] = 12'hBD9; tab_t[1] = 1'b0;
    req_index[8*2 +: 8] = 8'h00; tab_rgb[2] = 12'h9A4; tab_t[2] = 1'b1;
    req_index[8*3 +: 8] = 8'h5C; tab_rgb[3] = 12'hC65; tab_t[3] = 1'b0;

    // Reset held with every requester pending.
    Reset_n     = 1'b0;
    frame_start = 1'b0;
    req_valid   = 4'b1111;
    @(posedge Clk);
    @(posedge Clk);
    #1;
    check("reset_pal_index", 32'(pal_index), 32'h0);
    check("reset_rsp_valid", 32'(rsp_valid), 32'h0);
    check("reset_rsp_rgb", 32'({rsp_red, rsp_green, rsp_blue}), 32'h0);
    check("reset_rsp_transparent", 32'(rsp_transparent), 32'h0);
    check("reset_busy", 32'(busy), 32'h0);
    check("reset_req_ready", 32'(req_ready), 32'b0001);
    Reset_n = 1'b1;

    // Fairness: all valid for 8 cycles -> 0,1,2,3,0,1,2,3.
    step(4'b1111, 1'b0, 4'b0001, 1'b1);
    step(4'b1111, 1'b0, 4'b0010, 1'b1);
    step(4'b1111, 1'b0, 4'b0100, 1'b1);
    step(4'b1111, 1'b0, 4'b1000, 1'b1);
    step(4'b1111, 1'b0, 4'b0001, 1'b1);
    step(4'b1111, 1'b0, 4'b0010, 1'b1);
    step(4'b1111, 1'b0, 4'b0100, 1'b1);
    step(4'b1111, 1'b0, 4'b1000, 1'b1);
    idle(3);

    // Single requester 2 with index 0x10 -> 8/A/5; pointer moves to 3.
    req_index[8*2 +: 8] = 8'h10; tab_rgb[2] = 12'h8A5; tab_t[2] = 1'b0;
    step(4'b0100, 1'b0, 4'b0100, 1'b1);
    idle(3);

    // Wrap and skip: pointer at 3, only 0 and 1 pending.
    step(4'b0011, 1'b0, 4'b0001, 1'b1);
    step(4'b0011, 1'b0, 4'b0010, 1'b1);

    // frame_start with pointer at 2: grant 2 now, then 0 (not 3 order).
    step(4'b0101, 1'b1, 4'b0100, 1'b1);
    step(4'b0101, 1'b0, 4'b0001, 1'b1);
    idle(3);

    // Transparency then hold: requester 1 asks for index 0.
    req_index[8*1 +: 8] = 8'h00; tab_rgb[1] = 12'h9A4; tab_t[1] = 1'b1;
    step(4'b0010, 1'b0, 4'b0010, 1'b1);
    idle(4);
    check("hold_rsp_valid", 32'(rsp_valid), 32'h0);
    check("hold_rsp_rgb", 32'({rsp_red, rsp_green, rsp_blue}), 32'h9A4);
    check("hold_rsp_transparent", 32'(rsp_transparent), 32'h1);
    check("hold_pal_index", 32'(pal_index), 32'h00);
    check("hold_busy", 32'(busy), 32'h0);

    // Reset mid-flight: the accepted lookup for requester 2 must vanish.
    step(4'b1111, 1'b0, 4'b0100, 1'b0);
    Reset_n   = 1'b0;
    req_valid = '0;
    #1;
    check("midreset_busy", 32'(busy), 32'h0);
    check("midreset_rsp_valid", 32'(rsp_valid), 32'h0);
    check("midreset_pal_index", 32'(pal_index), 32'h0);
    @(posedge Clk);
    @(posedge Clk);
    #1;
    Reset_n = 1'b1;
    idle(3);
    step(4'b1000, 1'b0, 4'b1000, 1'b1);
    idle(4);

    check("scoreboard_empty", 32'(sb.size()), 32'h0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
